freq_counter_multi: RTL and testbench

FREQ_COUNTER_MULTI -- requirements
Module: freq_counter_multi

---
 rtl/freq_counter_multi.sv | 175 +++++++++++++++++
 tb/tb_freq_counter_multi.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter_multi.sv
// Gated frequency counter: counts selected edges of an asynchronous input over a
// programmable window and publishes the saturated count as BCD via a serial double-dabble.
module freq_counter_multi #(
    parameter int DIGITS         = 4,
    parameter int PERIOD_BITS    = 16,
    parameter int DEFAULT_PERIOD = 1200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   signal,
    input  logic [1:0]             edge_sel,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   period_load,
    output logic [4*DIGITS-1:0]    bcd,
    output logic                   valid,
    output logic                   overflow
);

    localparam int CNT_MAX    = 10**DIGITS - 1;
    localparam int CNT_BITS   = $clog2(CNT_MAX + 1);
    localparam int MIN_PERIOD = CNT_BITS + 2;
    localparam int BCD_W      = 4 * DIGITS;
    localparam int SH_W       = BCD_W + CNT_BITS;
    localparam int IT_W       = $clog2(CNT_BITS + 1);

    localparam logic [PERIOD_BITS-1:0] MIN_P     = PERIOD_BITS'(MIN_PERIOD);
    localparam logic [PERIOD_BITS-1:0] DEF_P     = PERIOD_BITS'(DEFAULT_PERIOD);
    localparam logic [PERIOD_BITS-1:0] P_ONE     = PERIOD_BITS'(1);
    localparam logic [CNT_BITS-1:0]    CNT_MAX_C = CNT_BITS'(CNT_MAX);
    localparam logic [CNT_BITS-1:0]    CNT_ONE   = CNT_BITS'(1);
    localparam logic [IT_W-1:0]        IT_LAST   = IT_W'(CNT_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PUBLISH} state_t;

    // Short windows would let a new snapshot arrive before the converter is idle.
    function automatic logic [PERIOD_BITS-1:0] clamp_period(input logic [PERIOD_BITS-1:0] p);
        return (p < MIN_P) ? MIN_P : p;
    endfunction

    function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] v);
        logic [SH_W-1:0] t;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[CNT_BITS+4*d +: 4] >= 4'd5) begin
                t[CNT_BITS+4*d +: 4] = t[CNT_BITS+4*d +: 4] + 4'd3;
            end
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

    logic                   sync1_q, sync2_q, hist_q;
    logic                   run_q;
    logic [PERIOD_BITS-1:0] gate_q, gate_d, upd_q, upd_d, pend_q, pend_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d, cnt_next;
    logic                   sticky_q, sticky_d, sticky_next;
    logic                   rise, fall, detect, closing, at_max;
    state_t                 state_q, state_d;
    logic [IT_W-1:0]        iter_q, iter_d;
    logic [SH_W-1:0]        sh_q, sh_d;
    logic                   osnap_q, osnap_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   ovf_q, ovf_d, valid_q, valid_d;

    assign rise = sync2_q & ~hist_q;
    assign fall = ~sync2_q & hist_q;

    always_comb begin
        detect = rise;
        case (edge_sel)
            2'b01:   detect = fall;
            2'b10:   detect = rise | fall;
            default: detect = rise;
        endcase
    end

    // Window timing and edge accumulation; the closing cycle's own edge goes into the snapshot.
    always_comb begin
        at_max      = (cnt_q == CNT_MAX_C);
        cnt_next    = (detect && !at_max) ? cnt_q + CNT_ONE : cnt_q;
        sticky_next = sticky_q | (detect & at_max);
        closing     = run_q && (gate_q == upd_q - P_ONE);
        gate_d      = gate_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        upd_d       = upd_q;
        if (closing) begin
            gate_d   = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
            upd_d    = pend_q;
        end else if (run_q) begin
            gate_d   = gate_q + P_ONE;
            cnt_d    = cnt_next;
            sticky_d = sticky_next;
        end
        pend_d = period_load ? clamp_period(period) : pend_q;
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        sh_d    = sh_q;
        osnap_d = osnap_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (closing) begin
                    sh_d    = {{BCD_W{1'b0}}, cnt_next};
                    osnap_d = sticky_next;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d   = dd_step(sh_q);
                iter_d = iter_q + 1'b1;
                if (iter_q == IT_LAST) begin
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                bcd_d   = sh_q[SH_W-1 -: BCD_W];
                ovf_d   = osnap_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
            run_q    <= 1'b0;
            gate_q   <= '0;
            upd_q    <= DEF_P;
            pend_q   <= DEF_P;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            state_q  <= IDLE;
            iter_q   <= '0;
            sh_q     <= '0;
            osnap_q  <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            sync1_q  <= signal;
            sync2_q  <= sync1_q;
            hist_q   <= sync2_q;
            run_q    <= 1'b1;
            gate_q   <= gate_d;
            upd_q    <= upd_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            state_q  <= state_d;
            iter_q   <= iter_d;
            sh_q     <= sh_d;
            osnap_q  <= osnap_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign bcd      = bcd_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_freq_counter_multi.sv
// Bench for freq_counter_multi: window counts derived from recorded input samples, BCD by arithmetic.
module tb_freq_counter_multi;
    localparam int PB   = 16;
    localparam int DEF  = 1200;
    localparam int LAT  = 15;
    localparam int MINP = 16;
    localparam int CMAX = 9999;

    logic          clk = 1'b0, reset = 1'b0, signal = 1'b0, period_load = 1'b0;
    logic [1:0]    edge_sel = 2'b00;
    logic [PB-1:0] period = '0;
    logic [15:0]   bcd;
    logic          valid, overflow;
    int            checks = 0, failures = 0;

    freq_counter_multi #(.DIGITS(4), .PERIOD_BITS(PB), .DEFAULT_PERIOD(DEF)) dut (
        .clk(clk), .reset(reset), .signal(signal), .edge_sel(edge_sel),
        .period(period), .period_load(period_load),
        .bcd(bcd), .valid(valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {int edge_n; int cnt; int bcd; bit ovf;} pub_t;
    pub_t expq[$];
    pub_t obsq[$];
    logic       s_h   [0:65535];
    logic [1:0] sel_h [0:65535];
    int e = 0, win_start = 2, next_close = DEF + 1, pend_m = DEF;
    int gen_mode = 0, half = 5, ph = 0;

    function automatic logic s_at(int j);
        if (j < 1) return 1'b0;
        return s_h[j];
    endfunction

    // Edge counted at clock edge j: input seen two and three samples earlier.
    function automatic int det_at(int j);
        logic o, n;
        o = s_at(j - 3);
        n = s_at(j - 2);
        case (sel_h[j])
            2'b01:   return (o && !n) ? 1 : 0;
            2'b10:   return (o != n) ? 1 : 0;
            default: return (!o && n) ? 1 : 0;
        endcase
    endfunction

    function automatic int to_bcd(int n);
        int r = 0;
        for (int d = 0; d < 4; d++) r += ((n / (10**d)) % 10) << (4 * d);
        return r;
    endfunction

    function automatic int from_bcd(int b);
        int r = 0;
        for (int d = 3; d >= 0; d--) r = r * 10 + ((b >> (4 * d)) & 15);
        return r;
    endfunction

    // Reference: windows back to back, first closes DEF edges after the start edge.
    always @(posedge clk) begin
        if (!reset) begin
            e = 0; win_start = 2; next_close = DEF + 1; pend_m = DEF;
            expq.delete();
        end else if (e < 65535) begin
            int c;
            pub_t p;
            e++;
            s_h[e]   = signal;
            sel_h[e] = edge_sel;
            if (e == next_close) begin
                c = 0;
                for (int j = win_start; j <= e; j++) c += det_at(j);
                p.edge_n = e + LAT;
                p.cnt    = (c > CMAX) ? CMAX : c;
                p.bcd    = to_bcd(p.cnt);
                p.ovf    = (c > CMAX);
                expq.push_back(p);
                win_start  = e + 1;
                next_close = e + pend_m;
            end
            if (period_load) pend_m = (int'(period) < MINP) ? MINP : int'(period);
        end
    end

    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) begin
            pub_t p;
            p.edge_n = e;
            p.bcd    = int'(bcd);
            p.cnt    = from_bcd(int'(bcd));
            p.ovf    = overflow;
            obsq.push_back(p);
        end
    end

    task automatic gen_step();
        case (gen_mode)
            1: begin
                ph++;
                if (ph >= half) begin ph = 0; signal = ~signal; end
            end
            2: if ($urandom_range(0, 3) == 0) signal = ~signal;
            default: ;
        endcase
    endtask

    task automatic run(int n);
        repeat (n) begin @(negedge clk); gen_step(); end
    endtask

    task automatic run_until(int t);
        int guard = 0;
        while (e < t && guard < 70000) begin run(1); guard++; end
        checks++;
        if (e < t) begin failures++; $display("FAIL run_until: reached edge %0d, required %0d", e, t); end
    endtask

    task automatic load(int p);
        @(negedge clk); period = PB'(p); period_load = 1'b1; gen_step();
        @(negedge clk); period_load = 1'b0; gen_step();
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0; signal = 1'b0; ph = 0; gen_mode = 0;
        repeat (3) @(negedge clk);
        obsq.delete();
        reset = 1'b1;
    endtask

    task automatic take(output bit more, output bit got, output pub_t x, output pub_t o);
        more = (expq.size() > 0) && (expq[0].edge_n <= e);
        got  = 1'b0;
        if (more) begin
            x = expq.pop_front();
            if (obsq.size() > 0) begin o = obsq.pop_front(); got = 1'b1; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bcd !== 16'h0) begin failures++; $display("FAIL rst_bcd: got %h, required 0000", bcd); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, required 0", valid); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b, required 0", overflow); end
        obsq.delete();
        reset = 1'b1;
        run(20);
        checks++; if (obsq.size() != 0) begin failures++; $display("FAIL rst_novalid: got %0d pulses, required 0", obsq.size()); end
    endtask

    task automatic test_rising();
        pub_t x, o; bit more, got; int idx = 0, prev = 0;
        do_reset(); edge_sel = 2'b00; gen_mode = 1; half = 5;
        run_until(DEF + 1 + 3 * DEF + 20);
        forever begin
            take(more, got, x, o);
            if (!more) break;
            checks++; if (!got) begin failures++; $display("FAIL rise_missing: no valid, required one at edge %0d", x.edge_n); continue; end
            checks++; if (o.edge_n != x.edge_n) begin failures++; $display("FAIL rise_time: got edge %0d, required %0d", o.edge_n, x.edge_n); end
            checks++; if (o.bcd != x.bcd) begin failures++; $display("FAIL rise_bcd: got %h, required %h", o.bcd, x.bcd); end
            checks++; if (o.ovf != x.ovf) begin failures++; $display("FAIL rise_ovf: got %b, required %b", o.ovf, x.ovf); end
            if (idx == 0) begin
                checks++; if (o.edge_n != DEF + 1 + LAT) begin failures++; $display("FAIL rise_first: got edge %0d, required %0d", o.edge_n, DEF + 1 + LAT); end
            end else begin
                checks++; if (o.bcd != 'h0120 || o.ovf) begin failures++; $display("FAIL rise_const: got %h/%b, required 0120/0", o.bcd, o.ovf); end
                checks++; if (o.edge_n - prev != DEF) begin failures++; $display("FAIL rise_spacing: got %0d, required %0d", o.edge_n - prev, DEF); end
            end
            prev = o.edge_n;
            idx++;
        end
        checks++; if (obsq.size() != 0) begin failures++; $display("FAIL rise_extra: got %0d extra valids, required 0", obsq.size()); end
        checks++; if (idx != 4) begin failures++; $display("FAIL rise_count: got %0d publishes, required 4", idx); end
    endtask

    task automatic test_edge_sel();
        pub_t x, o; bit more, got; int idx = 0;
        do_reset(); edge_sel = 2'b10; gen_mode = 1; half = 5;
        run_until(2 * DEF + 21);
        forever begin
            take(more, got, x, o);
            if (!more) break;
            checks++; if (!got) begin failures++; $display("FAIL both_missing: no valid, required one at edge %0d", x.edge_n); continue; end
            checks++; if (o.edge_n != x.edge_n || o.bcd != x.bcd || o.ovf != x.ovf) begin failures++; $display("FAIL both_pub: got %0d/%h/%b, required %0d/%h/%b", o.edge_n, o.bcd, o.ovf, x.edge_n, x.bcd, x.ovf); end
            if (idx > 0) begin
                checks++; if (o.bcd != 'h0240) begin failures++; $display("FAIL both_const: got %h, required 0240", o.bcd); end
            end
            idx++;
        end
        run_until(3000);
        edge_sel = 2'b01;
        run_until(5 * DEF + 21);
        forever begin
            take(more, got, x, o);
            if (!more) break;
            checks++; if (!got) begin failures++; $display("FAIL fall_missing: no valid, required one at edge %0d", x.edge_n); continue; end
            checks++; if (o.edge_n != x.edge_n || o.bcd != x.bcd || o.ovf != x.ovf) begin failures++; $display("FAIL fall_pub: got %0d/%h/%b, required %0d/%h/%b", o.edge_n, o.bcd, o.ovf, x.edge_n, x.bcd, x.ovf); end
            if (x.edge_n - LAT >= 4 * DEF + 1) begin
                checks++; if (o.bcd != 'h0120) begin failures++; $display("FAIL fall_const: got %h, required 0120", o.bcd); end
            end
            idx++;
        end
        checks++; if (obsq.size() != 0 || idx != 5) begin failures++; $display("FAIL sel_count: got %0d publishes %0d extra, required 5 and 0", idx, obsq.size()); end
    endtask

    task automatic test_overflow();
        pub_t x, o; bit more, got; int idx = 0;
        do_reset(); edge_sel = 2'b10; gen_mode = 1; half = 1;
        run(100);
        load(40000);
        run_until(30000);
        load(20);
        run_until(41100);
        gen_mode = 0;
        run_until(41245);
        forever begin
            take(more, got, x, o);
            if (!more) break;
            checks++; if (!got) begin failures++; $display("FAIL ovf_missing: no valid, required one at edge %0d", x.edge_n); continue; end
            checks++; if (o.edge_n != x.edge_n || o.bcd != x.bcd || o.ovf != x.ovf) begin failures++; $display("FAIL ovf_pub: got %0d/%h/%b, required %0d/%h/%b", o.edge_n, o.bcd, o.ovf, x.edge_n, x.bcd, x.ovf); end
            if (x.edge_n - LAT == 41201) begin
                checks++; if (o.bcd != 'h9999 || o.ovf !== 1'b1) begin failures++; $display("FAIL ovf_sat: got %h/%b, required 9999/1", o.bcd, o.ovf); end
            end
            if (x.edge_n - LAT == 41221) begin
                checks++; if (o.bcd != 'h0000 || o.ovf !== 1'b0) begin failures++; $display("FAIL ovf_static: got %h/%b, required 0000/0", o.bcd, o.ovf); end
            end
            idx++;
        end
        checks++; if (obsq.size() != 0 || idx != 3) begin failures++; $display("FAIL ovf_count: got %0d publishes %0d extra, required 3 and 0", idx, obsq.size()); end
    endtask

    task automatic test_short_period();
        pub_t x, o; bit more, got; int idx = 0, prev = 0;
        do_reset(); edge_sel = 2'b00; gen_mode = 1; half = 5;
        run_until(400);
        load(100);
        run_until(600);
        load(5);
        run_until(DEF + 1 + 16 * 10 + 20);
        forever begin
            take(more, got, x, o);
            if (!more) break;
            checks++; if (!got) begin failures++; $display("FAIL short_missing: no valid, required one at edge %0d", x.edge_n); continue; end
            checks++; if (o.edge_n != x.edge_n || o.bcd != x.bcd || o.ovf != x.ovf) begin failures++; $display("FAIL short_pub: got %0d/%h/%b, required %0d/%h/%b", o.edge_n, o.bcd, o.ovf, x.edge_n, x.bcd, x.ovf); end
            if (idx == 0) begin
                checks++; if (o.edge_n != DEF + 1 + LAT) begin failures++; $display("FAIL short_first: got edge %0d, required %0d", o.edge_n, DEF + 1 + LAT); end
            end else begin
                checks++; if (o.edge_n - prev != MINP) begin failures++; $display("FAIL short_spacing: got %0d, required %0d", o.edge_n - prev, MINP); end
            end
            prev = o.edge_n;
            idx++;
        end
        checks++; if (obsq.size() != 0 || idx != 11) begin failures++; $display("FAIL short_count: got %0d publishes %0d extra, required 11 and 0", idx, obsq.size()); end
    endtask

    task automatic test_random();
        pub_t x, o; bit more, got; int idx = 0, sum_dut = 0, sum_ref = 0, last_close = 0, total = 0;
        do_reset(); gen_mode = 2; edge_sel = 2'($urandom_range(0, 3));
        run(300);
        load(int'($urandom_range(0, 60)));
        repeat (60) begin
            run(int'($urandom_range(5, 40)));
            if ($urandom_range(0, 2) == 0) edge_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, 70)));
        end
        run(100);
        forever begin
            take(more, got, x, o);
            if (!more) break;
            checks++; if (!got) begin failures++; $display("FAIL rnd_missing: no valid, required one at edge %0d", x.edge_n); continue; end
            checks++; if (o.edge_n != x.edge_n || o.bcd != x.bcd || o.ovf != x.ovf) begin failures++; $display("FAIL rnd_pub: got %0d/%h/%b, required %0d/%h/%b", o.edge_n, o.bcd, o.ovf, x.edge_n, x.bcd, x.ovf); end
            sum_dut += o.cnt;
            sum_ref += x.cnt;
            last_close = x.edge_n - LAT;
            idx++;
        end
        for (int j = 2; j <= last_close; j++) total += det_at(j);
        checks++; if (sum_dut != total) begin failures++; $display("FAIL rnd_total: got %0d edges, required %0d (ref %0d)", sum_dut, total, sum_ref); end
        checks++; if (obsq.size() != 0 || idx < 10) begin failures++; $display("FAIL rnd_count: got %0d publishes %0d extra, required >=10 and 0", idx, obsq.size()); end
    endtask

    task automatic test_reset_mid_shift();
        pub_t x, o; bit more, got; int idx = 0;
        do_reset(); edge_sel = 2'b00; gen_mode = 1; half = 5;
        run(100);
        load(20);
        run_until(DEF + 6);
        #2 reset = 1'b0;
        #1;
        checks++; if (bcd !== 16'h0 || valid !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL mid_rst_out: got %h/%b/%b, required 0000/0/0", bcd, valid, overflow); end
        repeat (25) @(negedge clk);
        checks++; if (obsq.size() != 0) begin failures++; $display("FAIL mid_rst_valid: got %0d pulses, required 0", obsq.size()); end
        reset = 1'b1;
        run_until(2 * DEF + 1 + LAT + 20);
        forever begin
            take(more, got, x, o);
            if (!more) break;
            checks++; if (!got) begin failures++; $display("FAIL mid_missing: no valid, required one at edge %0d", x.edge_n); continue; end
            checks++; if (o.edge_n != x.edge_n || o.bcd != x.bcd || o.ovf != x.ovf) begin failures++; $display("FAIL mid_pub: got %0d/%h/%b, required %0d/%h/%b", o.edge_n, o.bcd, o.ovf, x.edge_n, x.bcd, x.ovf); end
            checks++; if (o.edge_n != (idx + 1) * DEF + 1 + LAT) begin failures++; $display("FAIL mid_time: got edge %0d, required %0d", o.edge_n, (idx + 1) * DEF + 1 + LAT); end
            idx++;
        end
        checks++; if (obsq.size() != 0 || idx != 2) begin failures++; $display("FAIL mid_count: got %0d publishes %0d extra, required 2 and 0", idx, obsq.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rising();
        test_edge_sel();
        test_overflow();
        test_short_period();
        test_random();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
